i2c_txn_scheduler: RTL and testbench

Round-robin scheduler that shares one `i2c_master` between `N_REQ` requesters. It accepts single-byte write or read transactions over a valid/ready handshake, then sequences the master's `i2c_en` and `ready` signals. It returns read data, or a timeout flag, to the winning requester. It sits between the AXI-side register blocks and the `i2c_master` instance, on the same `clk`/`rst`.

---
 rtl/i2c_sched_pkg.sv | 18 +
 rtl/i2c_rr_arbiter.sv | 37 +++
 rtl/i2c_txn_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// Shared types and widths for the I2C transaction scheduler.
//   state_t    : scheduler FSM encoding (IDLE, GRANT, ISSUE, BUSY, RESP)
//   I2C_ADDR_W : width of a 7-bit I2C slave address
//   I2C_DATA_W : width of one I2C data byte
package i2c_sched_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ISSUE = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req upward from ptr with wrap-around and returns the first set bit.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority requester index for this search
//   gnt     : one-hot grant (all zero when nothing is requested)
//   gnt_idx : binary index of the granted requester
//   any     : at least one request is set
module i2c_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one i2c_master between N_REQ requesters.
// Accepts single-byte read/write requests, drives the master's enable, and
// returns read data or a timeout flag to the granted requester.
//   clk, rst            : system clock, synchronous active-high reset
//   req_valid/addr/rw/wdata : per-requester request fields (packed slices)
//   req_ready           : one-cycle one-hot accept pulse
//   rsp_valid           : one-cycle one-hot completion pulse
//   rsp_rdata/timeout   : response payload, valid with rsp_valid
//   busy                : high whenever the FSM is not IDLE
//   m_addr/tx_data/rw/i2c_en : registered drive into the i2c_master
//   m_rx_data/m_ready   : status back from the i2c_master
module i2c_txn_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*7-1:0]      req_addr,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*8-1:0]      req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [6:0]              m_addr,
  output logic [7:0]              m_tx_data,
  output logic                    m_rw,
  output logic                    m_i2c_en,
  input  logic [7:0]              m_rx_data,
  input  logic                    m_ready
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]        req_ready_q, req_ready_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [I2C_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    busy_q, busy_d;
  logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [I2C_DATA_W-1:0]   m_tx_data_q, m_tx_data_d;
  logic                    m_rw_q, m_rw_d;
  logic                    m_i2c_en_q, m_i2c_en_d;

  logic [N_REQ-1:0]        arb_gnt;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_any;

  i2c_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    req_ready_d   = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    m_addr_d      = m_addr_q;
    m_tx_data_d   = m_tx_data_q;
    m_rw_d        = m_rw_q;
    m_i2c_en_d    = m_i2c_en_q;

    case (state_q)
      IDLE: begin
        // Only arbitrate once the master is back in its own idle state.
        if (m_ready && arb_any) begin
          gnt_d       = arb_gnt;
          ptr_d       = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          m_addr_d    = req_addr[arb_idx*I2C_ADDR_W +: I2C_ADDR_W];
          m_tx_data_d = req_wdata[arb_idx*I2C_DATA_W +: I2C_DATA_W];
          m_rw_d      = req_rw[arb_idx];
          req_ready_d = arb_gnt;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        m_i2c_en_d = 1'b1;
        cnt_d      = '0;
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (!m_ready) begin
          // Master has left its idle state; drop enable so it stops after one byte.
          m_i2c_en_d = 1'b0;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (cnt_q == CNT_LAST) begin
          m_i2c_en_d    = 1'b0;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = gnt_q;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (m_ready) begin
          rsp_rdata_d   = m_rw_q ? m_rx_data : '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = gnt_q;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          m_i2c_en_d    = 1'b0;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = gnt_q;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      m_addr_q      <= '0;
      m_tx_data_q   <= '0;
      m_rw_q        <= 1'b0;
      m_i2c_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      m_addr_q      <= m_addr_d;
      m_tx_data_q   <= m_tx_data_d;
      m_rw_q        <= m_rw_d;
      m_i2c_en_q    <= m_i2c_en_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign m_addr      = m_addr_q;
  assign m_tx_data   = m_tx_data_q;
  assign m_rw        = m_rw_q;
  assign m_i2c_en    = m_i2c_en_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a hand-driven i2c_master stub.
module tb_i2c_txn_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*7-1:0] req_addr;
  logic [N-1:0] req_rw;
  logic [N*8-1:0] req_wdata;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_rdata;
  logic         rsp_timeout;
  logic         busy;
  logic [6:0]   m_addr;
  logic [7:0]   m_tx_data;
  logic         m_rw;
  logic         m_i2c_en;
  logic [7:0]   m_rx_data;
  logic         m_ready;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_txn_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .m_addr(m_addr), .m_tx_data(m_tx_data), .m_rw(m_rw), .m_i2c_en(m_i2c_en),
    .m_rx_data(m_rx_data), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one transaction through the master stub; inputs change on negedges.
  task automatic run_txn(input logic [N-1:0] mask, input bit drop, input logic [7:0] rx,
                         input int busy_cycles, output logic [N-1:0] g,
                         output logic [7:0] rdata, output logic to, output int lat);
    req_valid = mask;
    lat = 0;
    g = '0;
    rdata = '0;
    to = 1'b0;
    while (req_ready == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (req_ready == '0) begin
      check("grant_wait", 64'(lat), 64'd1);
      return;
    end
    g = req_ready;
    if (drop) req_valid = '0;
    @(negedge clk);
    check("issue_en", 64'(m_i2c_en), 64'd1);
    m_ready = 1'b0;
    @(negedge clk);
    check("busy_en", 64'(m_i2c_en), 64'd0);
    repeat (busy_cycles) @(negedge clk);
    m_rx_data = rx;
    m_ready = 1'b1;
    @(negedge clk);
    check("rsp_onehot", 64'(rsp_valid), 64'(g));
    rdata = rsp_rdata;
    to = rsp_timeout;
    @(negedge clk);
    check("rsp_pulse_end", 64'({rsp_valid, busy}), 64'd0);
  endtask

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rx;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];
  logic [N-1:0] g;
  logic [7:0]   rd;
  logic         to;
  int           lat;
  int           cnt;
  int           order[5];
  int           seen;

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_rw = '0;
    m_rx_data = 8'h00;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*7 +: 7]  = 7'(8'h10 + i);
      req_wdata[i*8 +: 8] = 8'(8'hE0 + i);
    end

    vecs[0] = '{idx: 1, addr: 7'h50, rw: 1'b0, wdata: 8'hA5, rx: 8'hFF, exp_rdata: 8'h00};
    vecs[1] = '{idx: 2, addr: 7'h68, rw: 1'b1, wdata: 8'h00, rx: 8'h3C, exp_rdata: 8'h3C};
    vecs[2] = '{idx: 0, addr: 7'h11, rw: 1'b1, wdata: 8'h77, rx: 8'h81, exp_rdata: 8'h81};
    vecs[3] = '{idx: 3, addr: 7'h7F, rw: 1'b0, wdata: 8'h00, rx: 8'h55, exp_rdata: 8'h00};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
               m_addr, m_tx_data, m_rw, m_i2c_en}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Table-driven single transactions
    for (int v = 0; v < 4; v++) begin
      req_addr[vecs[v].idx*7 +: 7]  = vecs[v].addr;
      req_wdata[vecs[v].idx*8 +: 8] = vecs[v].wdata;
      req_rw[vecs[v].idx]           = vecs[v].rw;
      run_txn(N'(1 << vecs[v].idx), 1'b1, vecs[v].rx, 3, g, rd, to, lat);
      check("tbl_grant",   64'(g), 64'(1 << vecs[v].idx));
      check("tbl_latency", 64'(lat), 64'd1);
      check("tbl_addr",    64'(m_addr), 64'(vecs[v].addr));
      check("tbl_rw",      64'(m_rw), 64'(vecs[v].rw));
      check("tbl_txdata",  64'(m_tx_data), 64'(vecs[v].wdata));
      check("tbl_rdata",   64'(rd), 64'(vecs[v].exp_rdata));
      check("tbl_timeout", 64'(to), 64'd0);
      req_rw[vecs[v].idx] = 1'b0;
    end

    // Fairness from a fresh pointer: all four requesting
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b1111, 1'b0, 8'h00, 1, g, rd, to, lat);
      order[k] = onehot_idx(g);
      check("rr_back_to_back", 64'(lat), 64'd1);
    end
    check("rr_order0", 64'(order[0]), 64'd0);
    check("rr_order1", 64'(order[1]), 64'd1);
    check("rr_order2", 64'(order[2]), 64'd2);
    check("rr_order3", 64'(order[3]), 64'd3);
    check("rr_order4", 64'(order[4]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      run_txn(4'b1100, 1'b0, 8'h00, 1, g, rd, to, lat);
      order[k] = onehot_idx(g);
    end
    req_valid = '0;
    check("rr23_order", 64'({8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}),
          64'h02030203);

    // Timeout with a stuck master (m_ready never falls)
    @(negedge clk);
    req_valid = 4'b0001;
    m_ready = 1'b1;
    cnt = 0;
    while (req_ready == '0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("to_grant", 64'(req_ready), 64'b0001);
    req_valid = '0;
    cnt = 0;
    while (rsp_valid == '0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check("to_issue_en", 64'(m_i2c_en), 64'd1);
    end
    check("to_cycles", 64'(cnt), 64'd4097);
    check("to_flags", 64'({rsp_valid, rsp_timeout, rsp_rdata, m_i2c_en}),
          64'({4'b0001, 1'b1, 8'h00, 1'b0}));
    @(negedge clk);
    check("to_pulse_end", 64'(rsp_valid), 64'd0);
    @(negedge clk);

    // Master still busy when a request arrives
    m_ready = 1'b0;
    req_valid = 4'b0001;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready != '0) seen++;
    end
    check("mbusy_no_grant", 64'(seen), 64'd0);
    m_ready = 1'b1;
    run_txn(4'b0001, 1'b1, 8'h00, 1, g, rd, to, lat);
    check("mbusy_grant", 64'(g), 64'b0001);
    check("mbusy_latency", 64'(lat), 64'd1);

    // Reset while BUSY: silent abort, pointer back to 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("rb_grant", 64'(req_ready), 64'b0100);
    req_valid = '0;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    check("rb_in_busy", 64'({busy, m_i2c_en}), 64'b10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    check("rb_outputs",
          64'({req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
               m_addr, m_tx_data, m_rw, m_i2c_en}), 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("rb_no_rsp", 64'(seen), 64'd0);
    run_txn(4'b1111, 1'b1, 8'h00, 1, g, rd, to, lat);
    check("rb_ptr_zero", 64'(g), 64'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
